// File: rtl/jump_pkg.sv
// Shared kind encodings and link helper for the jump target unit.
// Imported by the top level and the return-address stack.
package jump_pkg;

    localparam int KIND_W = 3;

    localparam logic [KIND_W-1:0] KIND_J    = 3'd0;
    localparam logic [KIND_W-1:0] KIND_JAL  = 3'd1;
    localparam logic [KIND_W-1:0] KIND_JR   = 3'd2;
    localparam logic [KIND_W-1:0] KIND_JALR = 3'd3;
    localparam logic [KIND_W-1:0] KIND_BR   = 3'd4;

    // Return address skips the delay slot when one exists.
    function automatic int unsigned link_offset(input int unsigned delay_slot);
        return (delay_slot != 0) ? 32'd8 : 32'd4;
    endfunction

endpackage

// File: rtl/jump_target_unit_ras_stack.sv
// Circular return-address stack: push/pop in, top/empty/full and sticky ovf/unf out.
// Push when full overwrites the oldest entry; pop when empty only raises unf.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // ptr_q is the next free slot; the newest entry sits just below it.
    assign top   = mem_q[ptr_q - PW'(1)];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            ptr_d = ptr_q + PW'(1);
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - PW'(1);
                cnt_d = cnt_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[ptr_q] <= data;
        end
    end

endmodule

// File: rtl/jump_target_unit.sv
// Resolves J/JAL/JR/JALR/BR targets and link addresses, predicts JR via a RAS,
// and presents the result through one registered valid/ready output stage.
module jump_target_unit
    import jump_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INSTR_IDX_W = 26,
    parameter int IMM_W       = 16,
    parameter int RAS_DEPTH   = 4,
    parameter int DELAY_SLOT  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [KIND_W-1:0]      in_kind,
    input  logic [ADDR_W-1:0]      in_pc,
    input  logic [INSTR_IDX_W-1:0] in_index,
    input  logic [IMM_W-1:0]       in_imm,
    input  logic [ADDR_W-1:0]      in_rs_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [KIND_W-1:0]      out_kind,
    output logic [ADDR_W-1:0]      out_target,
    output logic [ADDR_W-1:0]      out_link,
    output logic [ADDR_W-1:0]      out_pred,
    output logic                   out_pred_hit,
    output logic                   out_misalign,
    output logic                   ras_overflow,
    output logic                   ras_underflow
);

    // Bits of the target replaced by {index, 2'b00} for J-type jumps.
    localparam logic [ADDR_W-1:0] IDX_MASK =
        ADDR_W'({(INSTR_IDX_W+2){1'b1}});
    localparam logic [ADDR_W-1:0] LINK_OFS =
        ADDR_W'(link_offset(DELAY_SLOT));

    logic                is_j, is_jal, is_jr, is_jalr, is_br;
    logic                accept;
    logic [ADDR_W-1:0]   p4, boff, jtgt;
    logic [ADDR_W-1:0]   ras_top;
    logic                ras_empty, ras_full;
    logic                unused_ras_full;

    logic                valid_q, valid_d;
    logic [KIND_W-1:0]   kind_q;
    logic [ADDR_W-1:0]   tgt_q, tgt_d;
    logic [ADDR_W-1:0]   link_q, link_d;
    logic [ADDR_W-1:0]   pred_q, pred_d;
    logic                hit_q, hit_d;
    logic                mis_q, mis_d;

    assign is_j    = (in_kind == KIND_J);
    assign is_jal  = (in_kind == KIND_JAL);
    assign is_jr   = (in_kind == KIND_JR);
    assign is_jalr = (in_kind == KIND_JALR);
    assign is_br   = (in_kind == KIND_BR);

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    assign p4   = in_pc + ADDR_W'(4);
    assign boff = ADDR_W'($signed(in_imm)) << 2;
    assign jtgt = (p4 & ~IDX_MASK) | (ADDR_W'(in_index) << 2);

    assign unused_ras_full = ras_full;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && (is_jal || is_jalr)),
        .pop   (accept && is_jr),
        .data  (link_d),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_overflow),
        .unf   (ras_underflow)
    );

    always_comb begin
        tgt_d  = p4;
        link_d = '0;
        pred_d = '0;
        hit_d  = 1'b0;
        mis_d  = 1'b0;
        unique case (1'b1)
            is_j, is_jal:   tgt_d = jtgt;
            is_jr, is_jalr: tgt_d = in_rs_val;
            is_br:          tgt_d = p4 + boff;
            default:        tgt_d = p4;
        endcase
        if (is_jal || is_jalr) begin
            link_d = in_pc + LINK_OFS;
        end
        if (is_jr || is_jalr) begin
            mis_d = (in_rs_val[1:0] != 2'b00);
        end
        if (is_jr && !ras_empty) begin
            pred_d = ras_top;
            hit_d  = (ras_top == in_rs_val);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            kind_q  <= '0;
            tgt_q   <= '0;
            link_q  <= '0;
            pred_q  <= '0;
            hit_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                kind_q <= in_kind;
                tgt_q  <= tgt_d;
                link_q <= link_d;
                pred_q <= pred_d;
                hit_q  <= hit_d;
                mis_q  <= mis_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign out_kind     = kind_q;
    assign out_target   = tgt_q;
    assign out_link     = link_q;
    assign out_pred     = pred_q;
    assign out_pred_hit = hit_q;
    assign out_misalign = mis_q;

endmodule

// File: tb/tb_jump_target_unit.sv
// Scoreboard bench for jump_target_unit: a queue-based RAS model predicts each
// result at accept time; results are compared when the output stage presents them.
module tb_jump_target_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_ready, out_valid;
    logic [2:0]  in_kind, out_kind;
    logic [31:0] in_pc, in_rs_val, out_target, out_link, out_pred;
    logic [25:0] in_index;
    logic [15:0] in_imm;
    logic        out_pred_hit, out_misalign, ras_overflow, ras_underflow;

    jump_target_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_pc(in_pc), .in_index(in_index), .in_imm(in_imm),
        .in_rs_val(in_rs_val), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_target(out_target), .out_link(out_link),
        .out_pred(out_pred), .out_pred_hit(out_pred_hit),
        .out_misalign(out_misalign), .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    // Second instance without a delay slot.
    logic        d_valid, d_ready, d_ovalid, d_hit, d_mis, d_ovf, d_unf;
    logic [2:0]  d_kind, d_okind;
    logic [31:0] d_pc, d_rs, d_tgt, d_link, d_pred;

    jump_target_unit #(.DELAY_SLOT(0)) dut_nds (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(d_valid), .in_ready(d_ready), .in_kind(d_kind),
        .in_pc(d_pc), .in_index(26'd0), .in_imm(16'd0),
        .in_rs_val(d_rs), .out_valid(d_ovalid), .out_ready(1'b1),
        .out_kind(d_okind), .out_target(d_tgt), .out_link(d_link),
        .out_pred(d_pred), .out_pred_hit(d_hit),
        .out_misalign(d_mis), .ras_overflow(d_ovf),
        .ras_underflow(d_unf)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] target;
        logic [31:0] link;
        logic [31:0] pred;
        logic        hit;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ras_m[$];
    bit          ovf_m, unf_m, mv;
    int          checks, failures;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] p4;
        e      = '0;
        e.kind = in_kind;
        p4     = in_pc + 32'd4;
        case (in_kind)
            3'd0, 3'd1: e.target = {p4[31:28], in_index, 2'b00};
            3'd2, 3'd3: e.target = in_rs_val;
            3'd4:       e.target = p4 + ({{16{in_imm[15]}}, in_imm} << 2);
            default:    e.target = p4;
        endcase
        if (in_kind == 3'd1 || in_kind == 3'd3) e.link = in_pc + 32'd8;
        e.mis = (in_kind == 3'd2 || in_kind == 3'd3) && (in_rs_val[1:0] != 2'b00);
        if (in_kind == 3'd2) begin
            if (ras_m.size() > 0) begin
                e.pred = ras_m.pop_back();
                e.hit  = (e.pred == in_rs_val);
            end else begin
                unf_m = 1'b1;
            end
        end
        if (in_kind == 3'd1 || in_kind == 3'd3) begin
            if (ras_m.size() == 4) begin
                void'(ras_m.pop_front());
                ovf_m = 1'b1;
            end
            ras_m.push_back(e.link);
        end
        return e;
    endfunction

    task automatic step();
        exp_t e;
        bit   acc;
        @(negedge clk);
        if (rst_n) begin
            chk("in_ready", in_ready, !mv || out_ready);
            chk("out_valid", out_valid, mv);
            chk("ovf_flag", ras_overflow, ovf_m);
            chk("unf_flag", ras_underflow, unf_m);
            if (mv) begin
                chk("sb_size", sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk("kind", out_kind, e.kind);
                    chk("target", out_target, e.target);
                    chk("link", out_link, e.link);
                    chk("pred", out_pred, e.pred);
                    chk("hit", out_pred_hit, e.hit);
                    chk("mis", out_misalign, e.mis);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            acc = in_valid && (!mv || out_ready) && !flush;
            if (acc) sb.push_back(predict());
            if (flush) mv = 1'b0;
            else if (acc) mv = 1'b1;
            else if (out_ready) mv = 1'b0;
        end else begin
            sb.delete();
            ras_m.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
            mv    = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] k, input logic [31:0] pc,
                       input logic [31:0] rs, input logic [25:0] idx,
                       input logic [15:0] imm);
        in_valid  = 1'b1;
        in_kind   = k;
        in_pc     = pc;
        in_rs_val = rs;
        in_index  = idx;
        in_imm    = imm;
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_kind"}, out_kind, 0);
        chk({tag, "_target"}, out_target, 0);
        chk({tag, "_link"}, out_link, 0);
        chk({tag, "_pred"}, out_pred, 0);
        chk({tag, "_hit"}, out_pred_hit, 0);
        chk({tag, "_mis"}, out_misalign, 0);
        chk({tag, "_ovf"}, ras_overflow, 0);
        chk({tag, "_unf"}, ras_underflow, 0);
    endtask

    initial begin
        checks = 0; failures = 0; mv = 0; ovf_m = 0; unf_m = 0;
        rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        in_kind = 0; in_pc = 0; in_rs_val = 0; in_index = 0; in_imm = 0;
        d_valid = 0; d_kind = 0; d_pc = 0; d_rs = 0;
        step();
        step();
        chk_zero("rst");
        rst_n = 1;
        step();

        req(3'd0, 32'h0040_0000, 0, 26'h0100040, 0);
        chk("j_target", out_target, 32'h0040_0100);
        chk("j_link", out_link, 32'h0);
        req(3'd4, 32'h0040_0010, 0, 0, 16'hFFFF);
        chk("br_back", out_target, 32'h0040_0010);
        req(3'd4, 32'hFFFF_FFF8, 0, 0, 16'h0001);
        chk("br_wrap", out_target, 32'h0000_0000);
        req(3'd7, 32'h0000_1000, 0, 0, 0);
        chk("none_tgt", out_target, 32'h0000_1004);

        req(3'd1, 32'h0040_0020, 0, 26'h0000010, 0);
        chk("jal_link", out_link, 32'h0040_0028);
        req(3'd2, 32'h0040_0100, 32'h0040_0028, 0, 0);
        chk("jr_pred", out_pred, 32'h0040_0028);
        chk("jr_hit", out_pred_hit, 1);

        for (int i = 0; i < 5; i++)
            req(3'd1, 32'h0050_0000 + 32'(i) * 32'h100, 0, 26'(i), 0);
        chk("ovf_set", ras_overflow, 1);
        for (int i = 4; i >= 0; i--)
            req(3'd2, 32'h0060_0000, 32'h0050_0008 + 32'(i) * 32'h100, 0, 0);
        chk("pop5_pred", out_pred, 0);
        chk("pop5_hit", out_pred_hit, 0);
        chk("unf_set", ras_underflow, 1);

        req(3'd3, 32'h0040_0200, 32'h0040_0302, 0, 0);
        chk("jalr_mis", out_misalign, 1);
        req(3'd2, 32'h0040_0300, 32'h0040_0208, 0, 0);
        chk("jr_mis_hit", out_pred_hit, 1);
        step();

        out_ready = 0;
        req(3'd4, 32'h0000_2000, 0, 0, 16'h0010);
        in_valid = 1; in_kind = 3'd0; in_pc = 32'h0000_3000; in_index = 26'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ready", in_ready, 0);
            chk("bp_target", out_target, 32'h0000_2044);
        end
        out_ready = 1;
        step();
        in_valid = 0;
        chk("bp_next", out_target, 32'h0000_0154);
        step();

        req(3'd1, 32'h0060_0000, 0, 0, 0);
        in_valid = 1; in_kind = 3'd1; in_pc = 32'h0070_0000; flush = 1;
        step();
        flush = 0; in_valid = 0;
        chk("flush_valid", out_valid, 0);
        req(3'd2, 32'h0000_0000, 32'h0060_0008, 0, 0);
        chk("flush_ras", out_pred, 32'h0060_0008);
        step();

        for (int i = 0; i < 3; i++)
            req(3'd1, 32'h0080_0000 + 32'(i) * 32'h40, 0, 0, 0);
        out_ready = 0;
        step();
        rst_n = 0;
        step();
        chk_zero("mid");
        rst_n = 1; out_ready = 1;
        req(3'd2, 32'h0000_0000, 32'h0080_0088, 0, 0);
        chk("post_pred", out_pred, 0);
        chk("post_unf", ras_underflow, 1);
        step();

        d_valid = 1; d_kind = 3'd1; d_pc = 32'h0040_0020;
        @(posedge clk); #1;
        chk("nds_link", d_link, 32'h0040_0024);
        d_kind = 3'd2; d_rs = 32'h0040_0024;
        @(posedge clk); #1;
        d_valid = 0;
        chk("nds_pred", d_pred, 32'h0040_0024);
        chk("nds_hit", d_hit, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
